// File: rtl/psum_accumulator.sv
// Partial-sum accumulator feeding the ReLU stage. Sums a group of per-lane
// partial-sum beats, then requantizes (arithmetic right shift), adds a
// per-lane bias and saturates each lane to DATA_WIDTH signed. The result is
// held under a valid/ready handshake until the consumer takes it.
module psum_accumulator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LENGTH     = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned SHIFT      = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear_i,
  input  logic                                  bias_we_i,
  input  logic [LENGTH-1:0][DATA_WIDTH-1:0]     bias_in_i,
  input  logic                                  psum_valid_i,
  output logic                                  psum_ready_o,
  input  logic                                  psum_last_i,
  input  logic [LENGTH-1:0][ACC_WIDTH-1:0]      psum_in_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [LENGTH-1:0][DATA_WIDTH-1:0]     out_o,
  output logic [LENGTH-1:0]                     sat_flag_o,
  output logic                                  busy_o
);

  // One guard bit above the accumulator so shift + bias cannot overflow.
  localparam int unsigned RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] SatMax =
      {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SatMin =
      {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e                              state_q, state_d;
  logic [LENGTH-1:0][ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [LENGTH-1:0][DATA_WIDTH-1:0]   bias_q, bias_d;
  logic [LENGTH-1:0][DATA_WIDTH-1:0]   out_q, out_d;
  logic [LENGTH-1:0]                   sat_q, sat_d;
  logic                                out_valid_q, out_valid_d;

  logic                                xfer;
  logic [LENGTH-1:0][ACC_WIDTH-1:0]    acc_next;
  logic [LENGTH-1:0][RW-1:0]           req;
  logic [LENGTH-1:0][DATA_WIDTH-1:0]   res;
  logic [LENGTH-1:0]                   res_sat;

  assign psum_ready_o = (state_q != StDrain);
  assign xfer         = psum_valid_i & psum_ready_o;
  assign busy_o       = (state_q != StIdle);
  assign out_valid_o  = out_valid_q;
  assign out_o        = out_q;
  assign sat_flag_o   = sat_q;

  // Per-lane next accumulator value and its requantized, saturated result.
  always_comb begin
    for (int i = 0; i < LENGTH; i++) begin
      // First beat of a group loads, later beats add with natural wrap.
      acc_next[i] = (state_q == StIdle) ? psum_in_i[i] : acc_q[i] + psum_in_i[i];
      req[i] = ($signed({acc_next[i][ACC_WIDTH-1], acc_next[i]}) >>> SHIFT)
             + $signed({{(RW-DATA_WIDTH){bias_q[i][DATA_WIDTH-1]}}, bias_q[i]});
      if ($signed(req[i]) > SatMax) begin
        res[i]     = SatMax[DATA_WIDTH-1:0];
        res_sat[i] = 1'b1;
      end else if ($signed(req[i]) < SatMin) begin
        res[i]     = SatMin[DATA_WIDTH-1:0];
        res_sat[i] = 1'b1;
      end else begin
        res[i]     = req[i][DATA_WIDTH-1:0];
        res_sat[i] = 1'b0;
      end
    end
  end

  // Bias register is independent of the group FSM and survives clear.
  always_comb begin
    bias_d = bias_we_i ? bias_in_i : bias_q;
  end

  // Group FSM: accept beats, latch the result on the last beat, hold it in DRAIN.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_d       = out_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    if (clear_i) begin
      state_d     = StIdle;
      acc_d       = '0;
      out_d       = '0;
      sat_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (xfer) begin
            acc_d = acc_next;
            if (psum_last_i) begin
              state_d     = StDrain;
              out_d       = res;
              sat_d       = res_sat;
              out_valid_d = 1'b1;
            end else begin
              state_d = StAccum;
            end
          end
        end
        StDrain: begin
          if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      bias_q      <= '0;
      out_q       <= '0;
      sat_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      out_q       <= out_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed vector table, hand-written handshake,
// bias, clear and reset sequences, then randomized groups against a model.
module tb_psum_accumulator;

  localparam int DW = 16;
  localparam int L  = 16;
  localparam int AW = 32;
  localparam int SH = 8;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   clear = 1'b0;
  logic                   bias_we = 1'b0;
  logic [L-1:0][DW-1:0]   bias_in = '0;
  logic                   psum_valid = 1'b0;
  logic                   psum_ready;
  logic                   psum_last = 1'b0;
  logic [L-1:0][AW-1:0]   psum_in = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [L-1:0][DW-1:0]   out;
  logic [L-1:0]           sat;
  logic                   busy;

  int total = 0;
  int bad   = 0;

  psum_accumulator #(
    .DATA_WIDTH(DW), .LENGTH(L), .ACC_WIDTH(AW), .SHIFT(SH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear),
    .bias_we_i   (bias_we),
    .bias_in_i   (bias_in),
    .psum_valid_i(psum_valid),
    .psum_ready_o(psum_ready),
    .psum_last_i (psum_last),
    .psum_in_i   (psum_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_o       (out),
    .sat_flag_o  (sat),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       nb;
    logic [2:0][31:0] p0;
    logic [2:0][31:0] p1;
    logic [15:0]      b0;
    logic [15:0]      b1;
    logic [15:0]      e0;
    logic [15:0]      e1;
    logic [1:0]       es;
  } vec_t;

  vec_t tbl [5];

  function automatic vec_t mk(input int nb, input int a0, input int a1, input int a2,
                              input int c0, input int c1, input int c2,
                              input logic [15:0] b0, input logic [15:0] b1,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [1:0] es);
    vec_t v;
    v.nb = 2'(nb);
    v.p0 = {a2, a1, a0};
    v.p1 = {c2, c1, c0};
    v.b0 = b0; v.b1 = b1; v.e0 = e0; v.e1 = e1; v.es = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bias(input logic [L-1:0][DW-1:0] b);
    bias_in = b;
    bias_we = 1'b1;
    step();
    bias_we = 1'b0;
  endtask

  task automatic beat(input logic [L-1:0][AW-1:0] p, input bit last);
    psum_in    = p;
    psum_valid = 1'b1;
    psum_last  = last;
    step();
    psum_valid = 1'b0;
    psum_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Reference: floor-divide by 2^SH, add signed bias, clamp to DW signed.
  function automatic logic [DW:0] ref_lane(input int s, input logic [DW-1:0] b);
    longint r;
    longint hi;
    r  = (longint'(s) >>> SH) + longint'($signed(b));
    hi = (longint'(1) <<< (DW - 1)) - 1;
    if (r > hi) return {1'b1, 1'b0, {(DW-1){1'b1}}};
    if (r < -hi - 1) return {1'b1, 1'b1, {(DW-1){1'b0}}};
    return {1'b0, r[DW-1:0]};
  endfunction

  task automatic model_out(input logic [L-1:0][AW-1:0] sumv, input logic [L-1:0][DW-1:0] b,
                           output logic [L-1:0][DW-1:0] eo, output logic [L-1:0] es);
    logic [DW:0] t;
    for (int i = 0; i < L; i++) begin
      t     = ref_lane(int'(sumv[i]), b[i]);
      eo[i] = t[DW-1:0];
      es[i] = t[DW];
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return $urandom_range(0, 32'h00FF_FFFF) - 32'h0080_0000;
      default: return $urandom_range(0, 40000) - 32'd20000;
    endcase
  endfunction

  initial begin
    logic [L-1:0][AW-1:0] pv;
    logic [L-1:0][AW-1:0] sums;
    logic [L-1:0][DW-1:0] bv;
    logic [L-1:0][DW-1:0] eo;
    logic [L-1:0][DW-1:0] held;
    logic [L-1:0]         es;
    int                   nb;

    tbl[0] = mk(3, 256, 512, -256, 100, 200, 300, 16'd3, 16'd0, 16'd5, 16'd2, 2'b00);
    tbl[1] = mk(1, 32'h7FFF_0000, 0, 0, 32'h8000_0000, 0, 0,
                16'd0, 16'd0, 16'h7FFF, 16'h8000, 2'b11);
    tbl[2] = mk(2, 32'h7FFF_FFFF, 1, 0, 32'h0000_FF00, 0, 0,
                16'd0, 16'd0, 16'h8000, 16'h00FF, 2'b01);
    tbl[3] = mk(1, -1, 0, 0, -300, 0, 0, 16'd0, 16'd2, 16'hFFFF, 16'h0000, 2'b00);
    tbl[4] = mk(1, 32'h007F_FF00, 0, 0, 32'hFF80_0000, 0, 0,
                16'd1, 16'hFFFF, 16'h7FFF, 16'h8000, 2'b11);

    // Reset state while reset is held.
    step();
    step();
    chk("rst_psum_ready", psum_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", out, '0);
    chk("rst_sat", sat, '0);
    reset = 1'b0;
    step();

    // Directed vector table.
    for (int k = 0; k < 5; k++) begin
      bv = '0;
      bv[0] = tbl[k].b0;
      bv[1] = tbl[k].b1;
      load_bias(bv);
      for (int j = 0; j < int'(tbl[k].nb); j++) begin
        pv = '0;
        pv[0] = tbl[k].p0[j];
        pv[1] = tbl[k].p1[j];
        beat(pv, j == int'(tbl[k].nb) - 1);
        if (j < int'(tbl[k].nb) - 1)
          chk($sformatf("vec%0d_midgroup_valid", k), out_valid, 1'b0);
      end
      chk($sformatf("vec%0d_valid", k), out_valid, 1'b1);
      chk($sformatf("vec%0d_out0", k), out[0], tbl[k].e0);
      chk($sformatf("vec%0d_out1", k), out[1], tbl[k].e1);
      chk($sformatf("vec%0d_sat", k), sat, {14'd0, tbl[k].es});
      chk($sformatf("vec%0d_ready_drain", k), psum_ready, 1'b0);
      drain();
      chk($sformatf("vec%0d_valid_after", k), out_valid, 1'b0);
      chk($sformatf("vec%0d_out0_retained", k), out[0], tbl[k].e0);
    end

    // Backpressure: result held while a new beat waits.
    load_bias('0);
    pv = '0;
    pv[0] = 32'd2560;
    beat(pv, 1'b1);
    held = out;
    chk("bp_first_out0", out[0], 16'd10);
    pv = '0;
    pv[0] = 32'd768;
    pv[3] = 32'd1000;
    psum_in = pv;
    psum_valid = 1'b1;
    psum_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_ready_low", psum_ready, 1'b0);
      chk("bp_valid_held", out_valid, 1'b1);
      chk("bp_out_stable", out, held);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_valid_drop", out_valid, 1'b0);
    chk("bp_ready_rise", psum_ready, 1'b1);
    step();
    psum_valid = 1'b0;
    psum_last = 1'b0;
    model_out(pv, '0, eo, es);
    chk("bp_second_valid", out_valid, 1'b1);
    chk("bp_second_out", out, eo);
    drain();

    // Bias written together with the last beat applies to the next group.
    bv = '0;
    bv[0] = 16'd1;
    load_bias(bv);
    bv[0] = 16'd7;
    bias_in = bv;
    bias_we = 1'b1;
    beat('0, 1'b1);
    bias_we = 1'b0;
    chk("bias_old_used", out[0], 16'd1);
    drain();
    beat('0, 1'b1);
    chk("bias_new_used", out[0], 16'd7);
    drain();

    // Clear mid-group discards accumulated beats and the coincident beat.
    bv = '0;
    bv[0] = 16'd4;
    load_bias(bv);
    pv = '0;
    pv[0] = 32'd1000;
    beat(pv, 1'b0);
    beat(pv, 1'b0);
    chk("clr_busy_before", busy, 1'b1);
    clear = 1'b1;
    pv[0] = 32'd5000;
    beat(pv, 1'b1);
    clear = 1'b0;
    chk("clr_busy", busy, 1'b0);
    chk("clr_valid", out_valid, 1'b0);
    pv = '0;
    pv[0] = 32'd512;
    beat(pv, 1'b1);
    eo = '0;
    eo[0] = 16'd6;
    chk("clr_next_valid", out_valid, 1'b1);
    chk("clr_next_out", out, eo);
    drain();

    // Asynchronous reset while holding a saturated result.
    load_bias('0);
    pv = '0;
    pv[0] = 32'h7FFF_0000;
    beat(pv, 1'b1);
    chk("ar_valid_before", out_valid, 1'b1);
    chk("ar_sat_before", sat[0], 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_out", out, '0);
    chk("ar_sat", sat, '0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_ready", psum_ready, 1'b1);
    step();
    reset = 1'b0;
    step();

    // Randomized groups against the reference model.
    for (int g = 0; g < 40; g++) begin
      for (int i = 0; i < L; i++) bv[i] = 16'($urandom);
      load_bias(bv);
      sums = '0;
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        for (int i = 0; i < L; i++) begin
          pv[i]   = rnd_val();
          sums[i] = sums[i] + pv[i];
        end
        if ($urandom_range(0, 1) == 1) step();
        beat(pv, j == nb - 1);
      end
      model_out(sums, bv, eo, es);
      chk($sformatf("rnd%0d_valid", g), out_valid, 1'b1);
      chk($sformatf("rnd%0d_out", g), out, eo);
      chk($sformatf("rnd%0d_sat", g), sat, es);
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) step();
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Upstream neighbour of the ReLU stage in the TTPU output path.
- Accumulates a group of partial-sum vectors from the systolic array, one ACC_WIDTH value per lane per beat.
- At the end of the group, requantizes each lane by an arithmetic right shift, adds a per-lane bias and saturates to DATA_WIDTH signed.
- Presents the result vector with a valid/ready handshake. Out connects directly to the ReLU input vector; out_valid is the ReLU enable source.

Parameters:
DATA_WIDTH, 16, output lane width (signed two's complement)
LENGTH, 16, number of lanes
ACC_WIDTH, 32, partial-sum and accumulator lane width (signed)
SHIFT, 8, requantization arithmetic right shift (0..ACC_WIDTH-1)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
clear  in  1  synchronous abort; returns the block to IDLE
bias_we  in  1  load bias_in into the bias register
bias_in  in  [LENGTH-1:0][DATA_WIDTH-1:0]  per-lane signed bias
psum_valid  in  1  partial-sum beat valid
psum_ready  out  1  block can accept a beat
psum_last  in  1  qualifies the final beat of a group
psum_in  in  [LENGTH-1:0][ACC_WIDTH-1:0]  signed partial sums
out_valid  out  1  Out holds a result
out_ready  in  1  consumer accepts the result
Out  out  [LENGTH-1:0][DATA_WIDTH-1:0]  saturated signed result
sat_flag  out  [LENGTH-1:0]  lane i of Out was clamped
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE; acc, bias, Out, sat_flag = 0; out_valid=0. psum_ready=1, busy=0 while reset is held.
- States:
  - IDLE: no group in progress.
  - ACCUM: group in progress.
  - DRAIN: result held for the consumer.
- psum_ready = (state != DRAIN), combinational from state. Beat transfer = psum_valid & psum_ready. psum_last is ignored without psum_valid.
- IDLE + transfer: acc <= psum_in (first beat loads, no add). Next state is ACCUM, or DRAIN if psum_last.
- ACCUM + transfer: acc <= acc + psum_in, lane-wise, wrapping mod 2^ACC_WIDTH (no internal saturation). Next state is DRAIN on psum_last.
- Last-beat transfer, per lane, in the same cycle:
  - s = acc_next, the value acc would take this cycle.
  - r = (s >>> SHIFT) + sext(bias), computed at ACC_WIDTH+1 bits. The shift floors toward -inf.
  - Out[i] <= clamp(r, -2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1); sat_flag[i] <= clamp active; out_valid <= 1.
- Latency: Out/out_valid are valid in the cycle after the last-beat transfer. A single-beat group (last in IDLE) is legal.
- DRAIN:
  - Out, sat_flag and out_valid are stable; psum_ready=0.
  - On out_valid & out_ready: out_valid <= 0, state <= IDLE. psum_ready rises the following cycle; no same-cycle turnaround.
  - Out and sat_flag retain their value after the handshake until the next result, clear or reset.
- bias_we: accepted in any state. The bias used for a result is the register value before the edge. A bias_we coincident with a last-beat transfer affects the next group only.
- clear: synchronous; priority over everything except reset. state=IDLE; acc, Out, sat_flag = 0; out_valid=0. Any in-flight beat that cycle is discarded. The bias register is kept.
- busy = (state != IDLE).
- Handshake assumption on out_valid: upstream must hold psum_in/psum_last stable while psum_valid & !psum_ready; the block does not capture beats in DRAIN.

Test Plan:
- Basic group: lane0 beats 256, 512, -256 (last), bias0=3, SHIFT=8 → one cycle after last, out_valid=1, Out[0]=5, sat_flag[0]=0. The other lanes follow independent values.
- Saturation, single beat: lane0=0x7FFF_0000, lane1=0x8000_0000, bias=0 → Out[0]=0x7FFF, Out[1]=0x8000, sat_flag[1:0]=2'b11. Accumulator wrap check: 0x7FFF_FFFF + 1 → acc=0x8000_0000.
- Floor shift / negative: lane0 single beat -1, bias0=0 → Out[0]=0xFFFF (−1). Lane0 −300 (0xFFFF_FED4), bias0=+2 → (−2)+2 = Out[0]=0.
- Backpressure: hold out_ready=0 for 5 cycles after a result while psum_valid=1 → psum_ready=0 and Out stable throughout. After out_ready pulses, out_valid drops, psum_ready=1 on the next cycle, and the pending beat is accepted as the first beat of a new group.
- Bias timing: bias_we with bias_in=7 in the same cycle as the last beat (old bias 1, sum 0) → Out=1. The next group, sum 0, gives Out=7.
- Abort paths: clear mid-ACCUM after 2 beats, then a 1-beat group of 512 → Out[0]=2+bias, no residue. Async reset asserted in DRAIN → out_valid, Out, sat_flag, busy = 0 immediately, before any clock edge.
